// File: rtl/fpaa_prog_sequencer.sv
// fpaa_prog_sequencer: per-island FPAA floating-gate programming sequencer driving the Vinj decoders,
// PROG/RUN switches and timed injection/tunnelling pulses.
module fpaa_prog_sequencer #(
  parameter int ROW_BITS = 6,
  parameter int COL_BITS = 6,
  parameter int CNT_W    = 16,
  parameter int NP_W     = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [ROW_BITS-1:0] cmd_row,
  input  logic [COL_BITS-1:0] cmd_col,
  input  logic [1:0]          cmd_mode,
  input  logic [NP_W-1:0]     cmd_npulse,
  input  logic [CNT_W-1:0]    cfg_settle,
  input  logic [CNT_W-1:0]    cfg_pulse_w,
  input  logic                abort,
  output logic [ROW_BITS-1:0] dec_row,
  output logic [COL_BITS-1:0] dec_col,
  output logic                dec_en,
  output logic                prog,
  output logic                run,
  output logic                vinj_pulse,
  output logic                vtun_pulse,
  output logic                busy,
  output logic                done,
  output logic [1:0]          status,
  output logic [NP_W-1:0]     pulse_cnt
);
  typedef enum logic [2:0] {IDLE, SETUP, PULSE, GAP, RELEASE, DONE} state_t;
  state_t r_state, w_next;
  logic [ROW_BITS-1:0] r_row;
  logic [COL_BITS-1:0] r_col;
  logic [1:0]          r_mode;
  logic [NP_W-1:0]     r_np;
  logic [NP_W-1:0]     r_cnt;
  logic [CNT_W-1:0]    r_settle_m1;
  logic [CNT_W-1:0]    r_pw_m1;
  logic [CNT_W-1:0]    r_tmr;
  logic [1:0]          r_status;
  logic                r_bad_done;
  logic                w_acc;
  logic                w_last;
  logic                w_active;
  logic                w_abort;
  logic                w_more;
  assign w_acc    = cmd_valid & cmd_ready;
  assign w_last   = r_tmr == '0;
  assign w_active = r_state inside {SETUP, PULSE, GAP, RELEASE};
  assign w_abort  = abort & (r_state inside {SETUP, PULSE, GAP});
  assign w_more   = ({1'b0, r_cnt} + 1'b1) < {1'b0, r_np};
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = (w_acc && cmd_mode != 2'b11) ? SETUP : IDLE;
      SETUP:   w_next = w_abort ? RELEASE : !w_last ? SETUP :
                        (r_np != '0 && !r_mode[1]) ? PULSE : RELEASE;
      PULSE:   w_next = w_abort ? RELEASE : !w_last ? PULSE : w_more ? GAP : RELEASE;
      GAP:     w_next = w_abort ? RELEASE : w_last ? PULSE : GAP;
      RELEASE: w_next = w_last ? DONE : RELEASE;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_row       <= '0;
      r_col       <= '0;
      r_mode      <= '0;
      r_np        <= '0;
      r_cnt       <= '0;
      r_settle_m1 <= '0;
      r_pw_m1     <= '0;
      r_tmr       <= '0;
      r_status    <= '0;
      r_bad_done  <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_bad_done <= w_acc && cmd_mode == 2'b11;
      if (w_acc) begin
        r_row       <= cmd_row;
        r_col       <= cmd_col;
        r_mode      <= cmd_mode;
        r_np        <= cmd_npulse;
        r_cnt       <= '0;
        r_settle_m1 <= (cfg_settle == '0) ? '0 : cfg_settle - 1'b1;
        r_pw_m1     <= (cfg_pulse_w == '0) ? '0 : cfg_pulse_w - 1'b1;
        r_tmr       <= (cfg_settle == '0) ? '0 : cfg_settle - 1'b1;
        r_status    <= (cmd_mode == 2'b11) ? 2'b10 : 2'b00;
      end else begin
        if (w_next != r_state)
          r_tmr <= (w_next == PULSE || w_next == GAP) ? r_pw_m1 : r_settle_m1;
        else if (!w_last)
          r_tmr <= r_tmr - 1'b1;
        if (w_abort)
          r_status <= 2'b01;
        // a pulse counts once its full width has elapsed; saturate at the request
        if (r_state == PULSE && w_last && r_cnt < r_np)
          r_cnt <= r_cnt + 1'b1;
      end
    end
  end
  assign cmd_ready  = r_state == IDLE;
  assign dec_row    = w_active ? r_row : '0;
  assign dec_col    = w_active ? r_col : '0;
  assign dec_en     = w_active;
  assign prog       = (r_state inside {SETUP, PULSE, GAP}) && r_mode != 2'b10;
  assign run        = r_state == IDLE || r_state == DONE;
  assign vinj_pulse = r_state == PULSE && r_mode == 2'b00;
  assign vtun_pulse = r_state == PULSE && r_mode == 2'b01;
  assign busy       = r_state != IDLE;
  assign done       = r_state == DONE || r_bad_done;
  assign status     = r_status;
  assign pulse_cnt  = r_cnt;
endmodule

// File: tb/tb_fpaa_prog_sequencer.sv
// tb_fpaa_prog_sequencer: table-driven command vectors with a scoreboard queue, plus abort,
// back-to-back and mid-command reset sequences.
module tb_fpaa_prog_sequencer;
  logic        clk = 0;
  logic        reset = 1;
  logic        cmd_valid = 0;
  logic        cmd_ready;
  logic [5:0]  cmd_row = 0, cmd_col = 0;
  logic [1:0]  cmd_mode = 0;
  logic [7:0]  cmd_npulse = 0;
  logic [15:0] cfg_settle = 0, cfg_pulse_w = 0;
  logic        abort = 0;
  logic [5:0]  dec_row, dec_col;
  logic        dec_en, prog, run, vinj_pulse, vtun_pulse, busy, done;
  logic [1:0]  status;
  logic [7:0]  pulse_cnt;
  int errors = 0, checks = 0;

  fpaa_prog_sequencer dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_row(cmd_row), .cmd_col(cmd_col), .cmd_mode(cmd_mode), .cmd_npulse(cmd_npulse),
    .cfg_settle(cfg_settle), .cfg_pulse_w(cfg_pulse_w), .abort(abort),
    .dec_row(dec_row), .dec_col(dec_col), .dec_en(dec_en), .prog(prog), .run(run),
    .vinj_pulse(vinj_pulse), .vtun_pulse(vtun_pulse), .busy(busy), .done(done),
    .status(status), .pulse_cnt(pulse_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int row, col, mode, np, settle, pw, abort_at;
    int st, cnt, done_idx, npulse_cyc, prog_cyc, first;
  } vec_t;

  vec_t sb[$];
  vec_t tbl[6];

  function automatic vec_t mk(int row, int col, int mode, int np, int settle, int pw);
    vec_t v;
    int s = settle == 0 ? 1 : settle;
    int w = pw == 0 ? 1 : pw;
    bit pul = mode < 2 && np != 0;
    v.row = row; v.col = col; v.mode = mode; v.np = np; v.settle = settle; v.pw = pw;
    v.abort_at = -1;
    v.st = mode == 3 ? 2 : 0;
    v.cnt = pul ? np : 0;
    v.done_idx = mode == 3 ? 0 : 2 * s + (pul ? (2 * np - 1) * w : 0);
    v.npulse_cyc = pul ? np * w : 0;
    v.prog_cyc = (mode >= 2) ? 0 : s + (pul ? (2 * np - 1) * w : 0);
    v.first = pul ? s : -1;
    return v;
  endfunction

  function automatic logic [29:0] outs();
    return {cmd_ready, dec_en, prog, run, vinj_pulse, vtun_pulse, busy, done,
            status, pulse_cnt, dec_row, dec_col};
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    @(negedge clk);
    cmd_row = v.row[5:0]; cmd_col = v.col[5:0]; cmd_mode = v.mode[1:0];
    cmd_npulse = v.np[7:0]; cfg_settle = v.settle[15:0]; cfg_pulse_w = v.pw[15:0];
    cmd_valid = 1;
  endtask

  task automatic run_cmd(input vec_t v);
    vec_t e;
    int k = 0, n_den = 0, n_inj = 0, n_tun = 0, n_prog = 0, first = -1, bad = 0;
    bit got = 0, rdy = 0, bsy = 0;
    sb.push_back(v);
    drive(v);
    @(posedge clk);
    #1 cmd_valid = 0;
    cmd_row = 6'h2a; cmd_col = 6'h15; cmd_mode = 2'b11; cmd_npulse = 8'hff;
    cfg_settle = 16'd99; cfg_pulse_w = 16'd99;
    while (!got && k < 2000) begin
      @(negedge clk);
      if (done) begin
        got = 1; rdy = cmd_ready; bsy = busy;
      end else begin
        n_den += int'(dec_en); n_inj += int'(vinj_pulse);
        n_tun += int'(vtun_pulse); n_prog += int'(prog);
        if (first < 0 && (vinj_pulse || vtun_pulse)) first = k;
        if (vinj_pulse && vtun_pulse) bad++;
        if ((vinj_pulse || vtun_pulse) && !(prog && dec_en)) bad++;
        if (dec_en && (dec_row != v.row[5:0] || dec_col != v.col[5:0])) bad++;
        if (dec_en == run) bad++;
        k++;
      end
      abort = (v.abort_at == k - 1) && !got;
    end
    abort = 0;
    e = sb.pop_front();
    chk("done_seen", int'(got), 1);
    chk("done_idx", k, e.done_idx);
    chk("status", int'(status), e.st);
    chk("pulse_cnt", int'(pulse_cnt), e.cnt);
    chk("dec_en_cycles", n_den, e.done_idx);
    chk("vinj_cycles", n_inj, e.mode == 0 ? e.npulse_cyc : 0);
    chk("vtun_cycles", n_tun, e.mode == 1 ? e.npulse_cyc : 0);
    chk("prog_cycles", n_prog, e.prog_cyc);
    chk("first_pulse", first, e.first);
    chk("invariants", bad, 0);
    chk("ready_at_done", int'(rdy), int'(e.mode == 3));
    chk("busy_at_done", int'(bsy), int'(e.mode != 3));
  endtask

  initial begin
    vec_t v;
    int k;
    tbl[0] = mk(5, 9, 0, 3, 4, 2);
    tbl[1] = mk(3, 4, 1, 1, 2, 0);
    tbl[2] = mk(10, 20, 2, 5, 3, 2);
    tbl[3] = mk(1, 2, 0, 0, 3, 1);
    tbl[4] = mk(7, 7, 3, 4, 5, 5);
    tbl[5] = mk(63, 63, 1, 2, 0, 3);
    repeat (3) @(posedge clk);
    #1 reset = 0;
    @(negedge clk);
    chk("reset_state", int'(outs()), int'({1'b1, 1'b0, 1'b0, 1'b1, 4'b0, 2'b0, 8'b0, 12'b0}));
    foreach (tbl[i]) run_cmd(tbl[i]);

    // abort on the first cycle of the second injection pulse
    v = mk(5, 9, 0, 3, 4, 2);
    v.abort_at = 8; v.st = 1; v.cnt = 1; v.done_idx = 13;
    v.npulse_cyc = 3; v.prog_cyc = 9; v.first = 4;
    run_cmd(v);

    // cmd_valid held high across DONE: accepted in the IDLE cycle after done
    v = mk(11, 12, 2, 0, 1, 1);
    drive(v);
    k = 0;
    do begin @(negedge clk); k++; end while (!done && k < 100);
    chk("b2b_done_seen", int'(done), 1);
    chk("b2b_ready_in_done", int'(cmd_ready), 0);
    @(negedge clk);
    chk("b2b_idle_ready", int'({cmd_ready, busy}), 2);
    @(negedge clk);
    cmd_valid = 0;
    chk("b2b_second_setup", int'({busy, dec_en, dec_row}), int'({2'b11, 6'd11}));
    k = 0;
    do begin @(negedge clk); k++; end while (!done && k < 100);
    chk("b2b_second_done", int'({done, status}), 4);

    // reset asserted mid-GAP of a T1-style command
    v = mk(5, 9, 0, 3, 4, 2);
    drive(v);
    @(posedge clk);
    #1 cmd_valid = 0;
    repeat (7) @(negedge clk);
    chk("gap_before_reset", int'({prog, dec_en, vinj_pulse, pulse_cnt}), int'({3'b110, 8'd1}));
    reset = 1;
    @(negedge clk);
    chk("reset_mid_gap", int'(outs()), int'({1'b1, 1'b0, 1'b0, 1'b1, 4'b0, 2'b0, 8'b0, 12'b0}));
    reset = 0;
    run_cmd(tbl[1]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
